// File: rtl/svcs_trnx_arbiter_if.sv
// Requester/bridge handshake bundle for the SVCS transaction arbiter.
// slave: arbiter side; master: producers plus bridge side.
interface svcs_trnx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_type;
    logic [N_REQ*DATA_W-1:0] req_id;
    logic [N_REQ*DATA_W-1:0] req_dtype;
    logic [N_REQ*LEN_W-1:0]  req_len;
    logic [N_REQ-1:0]        req_ack;
    logic [N_REQ-1:0]        pl_valid;
    logic [N_REQ*DATA_W-1:0] pl_data;
    logic [N_REQ-1:0]        pl_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_sof;
    logic                    out_last;

    modport slave (
        input  req_valid, req_type, req_id, req_dtype, req_len,
        input  pl_valid, pl_data, out_ready,
        output req_ack, pl_ready, out_valid, out_data,
        output out_sof, out_last
    );

    modport master (
        output req_valid, req_type, req_id, req_dtype, req_len,
        output pl_valid, pl_data, out_ready,
        input  req_ack, pl_ready, out_valid, out_data,
        input  out_sof, out_last
    );
endinterface

// File: rtl/svcs_trnx_arbiter.sv
// Round-robin SVCS transaction arbiter: 4-word header then payload pass-through.
// Optional payload-stall watchdog enabled by SVCS_ARB_TIMEOUT_EN.
module svcs_trnx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 13,
    parameter int MAX_PAYLOAD = 4096,
    parameter int TIMEOUT_CYC = 256,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    svcs_trnx_arbiter_if.slave bus,
    output logic             busy,
    output logic [IDX_W-1:0] grant_id,
    output logic             err_len,
    output logic             timeout
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t            state_q, state_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [DATA_W-1:0] type_q, type_d;
    logic [DATA_W-1:0] id_q, id_d;
    logic [DATA_W-1:0] dtype_q, dtype_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              err_q, err_d;

    logic              found;
    logic [IDX_W-1:0]  pick;
    int                idx;
    logic [DATA_W-1:0] sel_type, sel_id, sel_dtype;
    logic [LEN_W-1:0]  sel_len;
    logic              pl_valid_g;
    logic [DATA_W-1:0] pl_data_g;

    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_sof;
    logic              o_last;
    logic [N_REQ-1:0]  o_pl_ready;

`ifdef SVCS_ARB_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
    logic [ST_W-1:0] stall_q, stall_d;
    logic            to_q, to_d;
    logic            tmo_q, tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        type_d     = type_q;
        id_d       = id_q;
        dtype_d    = dtype_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        err_d      = 1'b0;
        o_valid    = 1'b0;
        o_data     = '0;
        o_sof      = 1'b0;
        o_last     = 1'b0;
        o_pl_ready = '0;
        found      = 1'b0;
        pick       = '0;
        idx        = 0;
        sel_type   = '0;
        sel_id     = '0;
        sel_dtype  = '0;
        sel_len    = '0;
        pl_valid_g = 1'b0;
        pl_data_g  = '0;
`ifdef SVCS_ARB_TIMEOUT_EN
        stall_d    = stall_q;
        to_d       = to_q;
        tmo_d      = 1'b0;
`endif

        // first requesting index at or after rr_q, wrapping
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == pick) begin
                sel_type  = bus.req_type[i*DATA_W +: DATA_W];
                sel_id    = bus.req_id[i*DATA_W +: DATA_W];
                sel_dtype = bus.req_dtype[i*DATA_W +: DATA_W];
                sel_len   = bus.req_len[i*LEN_W +: LEN_W];
            end
            if (IDX_W'(i) == grant_q) begin
                pl_valid_g = bus.pl_valid[i];
                pl_data_g  = bus.pl_data[i*DATA_W +: DATA_W];
            end
        end

        unique case (state_q)
            IDLE: begin
`ifdef SVCS_ARB_TIMEOUT_EN
                stall_d = '0;
                to_d    = 1'b0;
`endif
                if (found) begin
                    grant_d     = pick;
                    rr_d        = (pick == IDX_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
                    type_d      = sel_type;
                    id_d        = sel_id;
                    dtype_d     = sel_dtype;
                    len_d       = sel_len;
                    ack_d[pick] = 1'b1;
                    if (sel_len > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        hdr_idx_d = 2'd0;
                        state_d   = HDR;
                    end
                end
            end

            HDR: begin
                o_valid = 1'b1;
                o_sof   = (hdr_idx_q == 2'd0);
                o_last  = (hdr_idx_q == 2'd3) && (len_q == '0);
                unique case (hdr_idx_q)
                    2'd0:    o_data = type_q;
                    2'd1:    o_data = id_q;
                    2'd2:    o_data = dtype_q;
                    default: o_data = {{(DATA_W-LEN_W){1'b0}}, len_q};
                endcase
                if (bus.out_ready) begin
                    if (hdr_idx_q == 2'd3) begin
                        cnt_d   = len_q;
                        state_d = (len_q != '0) ? PAYLOAD : IDLE;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end

            PAYLOAD: begin
                o_valid = pl_valid_g;
                o_data  = pl_data_g;
                o_last  = (cnt_q == ONE);
                for (int i = 0; i < N_REQ; i++) begin
                    o_pl_ready[i] = (IDX_W'(i) == grant_q) && bus.out_ready;
                end
`ifdef SVCS_ARB_TIMEOUT_EN
                // after the watchdog fires the rest is padded with zeros
                if (to_q) begin
                    o_valid    = 1'b1;
                    o_data     = '0;
                    o_pl_ready = '0;
                end
                if (o_valid && bus.out_ready) begin
                    stall_d = '0;
                end else if (!to_q && !pl_valid_g) begin
                    if (stall_q == ST_W'(TIMEOUT_CYC - 1)) begin
                        to_d  = 1'b1;
                        tmo_d = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
`endif
                if (o_valid && bus.out_ready) begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hdr_idx_q <= 2'd0;
            grant_q   <= '0;
            rr_q      <= '0;
            type_q    <= '0;
            id_q      <= '0;
            dtype_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            type_q    <= type_d;
            id_q      <= id_d;
            dtype_q   <= dtype_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

`ifdef SVCS_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            to_q    <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            to_q    <= to_d;
            tmo_q   <= tmo_d;
        end
    end
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    assign bus.req_ack   = ack_q;
    assign bus.pl_ready  = o_pl_ready;
    assign bus.out_valid = o_valid;
    assign bus.out_data  = o_data;
    assign bus.out_sof   = o_sof;
    assign bus.out_last  = o_last;
    assign busy          = (state_q != IDLE);
    assign grant_id      = grant_q;
    assign err_len       = err_q;
endmodule

// File: tb/tb_svcs_trnx_arbiter.sv
// Directed bench for svcs_trnx_arbiter: producers, stream model, checker.
// Define SVCS_ARB_TIMEOUT_EN to also exercise the stall watchdog.
module tb_svcs_trnx_arbiter;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int LW  = 13;
    localparam int MAXP = 4096;
    localparam int TMO = 16;

    typedef struct {
        logic [31:0] t;
        logic [31:0] id;
        logic [31:0] dt;
        logic [12:0] len;
    } hdr_t;

    typedef struct {
        logic [31:0] d;
        logic        sof;
        logic        last;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [1:0] grant_id;
    logic       err_len;
    logic       timeout;

    svcs_trnx_arbiter_if #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW)) bus ();

    svcs_trnx_arbiter #(
        .N_REQ(N), .DATA_W(DW), .LEN_W(LW),
        .MAX_PAYLOAD(MAXP), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .busy(busy), .grant_id(grant_id),
        .err_len(err_len), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    hdr_t        hq[N][$];
    logic [31:0] plq[N][$];
    logic [31:0] epl[N][$];
    word_t       expq[$];
    int          expg[$];
    logic [31:0] log_q[$];
    logic [N-1:0] plfire = '0;
    int          rmode = 0;
    bit          mute = 1'b0;
    bit          nopl = 1'b0;
    int          tmo_cnt = 0;
    int          err_cnt = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected / bound expired", nm);
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (hq[i].size() != 0 || plq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Producers and model update: just after each rising edge.
    initial begin : drv
        hdr_t h;
        word_t w;
        bus.req_valid = '0;
        bus.req_type  = '0;
        bus.req_id    = '0;
        bus.req_dtype = '0;
        bus.req_len   = '0;
        bus.pl_valid  = '0;
        bus.pl_data   = '0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rst_n && bus.req_ack[i]) begin
                    if (expg.size() == 0) fail("ack_unexpected");
                    else chk("grant_order", i, expg.pop_front());
                    chk("grant_id", grant_id, i);
                    if (hq[i].size() == 0) begin
                        fail("ack_no_header");
                    end else begin
                        h = hq[i].pop_front();
                        if (int'(h.len) > MAXP) begin
                            chk("err_len_pulse", err_len, 1);
                            chk("err_no_valid", bus.out_valid, 0);
                        end else begin
                            chk("err_len_quiet", err_len, 0);
                            chk("first_word_lat", bus.out_valid, 1);
                            w = '{d: h.t, sof: 1'b1, last: 1'b0};
                            expq.push_back(w);
                            w = '{d: h.id, sof: 1'b0, last: 1'b0};
                            expq.push_back(w);
                            w = '{d: h.dt, sof: 1'b0, last: 1'b0};
                            expq.push_back(w);
                            w = '{d: {19'd0, h.len}, sof: 1'b0,
                                  last: (h.len == 0)};
                            expq.push_back(w);
                            for (int k = 0; k < int'(h.len); k++) begin
                                w.d    = epl[i].pop_front();
                                w.sof  = 1'b0;
                                w.last = (k == int'(h.len) - 1);
                                expq.push_back(w);
                            end
                        end
                    end
                end
                if (plfire[i] && plq[i].size() != 0) void'(plq[i].pop_front());
            end
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i] = (hq[i].size() != 0);
                if (hq[i].size() != 0) begin
                    bus.req_type[i*DW +: DW]  = hq[i][0].t;
                    bus.req_id[i*DW +: DW]    = hq[i][0].id;
                    bus.req_dtype[i*DW +: DW] = hq[i][0].dt;
                    bus.req_len[i*LW +: LW]   = hq[i][0].len;
                end
                bus.pl_valid[i] = (plq[i].size() != 0);
                bus.pl_data[i*DW +: DW] = (plq[i].size() != 0) ? plq[i][0] : '0;
            end
            if (rmode == 1) bus.out_ready = ~bus.out_ready;
            else bus.out_ready = 1'b1;
        end
    end

    // Checker: mid-cycle, every cycle.
    initial begin : mon
        word_t w;
        bit    held = 1'b0;
        logic [33:0] prev = '0;
        forever begin
            @(negedge clk);
            plfire = bus.pl_valid & bus.pl_ready;
            if (mute || !rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_stable",
                        {bus.out_data, bus.out_sof, bus.out_last}, prev);
                end
                held = bus.out_valid && !bus.out_ready;
                prev = {bus.out_data, bus.out_sof, bus.out_last};
                if (bus.out_valid && bus.out_ready) begin
                    if (expq.size() == 0) begin
                        fail("word_unexpected");
                    end else begin
                        w = expq.pop_front();
                        chk("out_data", bus.out_data, w.d);
                        chk("out_sof", bus.out_sof, w.sof);
                        chk("out_last", bus.out_last, w.last);
                    end
                    log_q.push_back(bus.out_data);
                end
                if (bus.pl_ready != '0)
                    chk("pl_ready_onehot",
                        $onehot(bus.pl_ready) && bus.out_ready, 1);
                if (nopl) chk("len0_pl_ready", bus.pl_ready, 0);
                if (timeout) tmo_cnt++;
                if (err_len) err_cnt++;
            end
        end
    end

    task automatic wait_done(string nm);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while ((expq.size() != 0 || expg.size() != 0 || pending() || busy)
                   && c < 2000);
        if (c >= 2000) fail(nm);
    endtask

    task automatic add_hdr(int r, logic [31:0] t, logic [31:0] id,
                           logic [31:0] dt, logic [12:0] len);
        hdr_t h;
        h = '{t: t, id: id, dt: dt, len: len};
        hq[r].push_back(h);
    endtask

    task automatic add_pl(int r, logic [31:0] d);
        plq[r].push_back(d);
        epl[r].push_back(d);
    endtask

    task automatic chk_t1_log(string nm);
        logic [31:0] lit[6];
        lit = '{32'hA1, 32'd5, 32'hD2, 32'd2, 32'h11, 32'h22};
        chk({nm, "_len"}, log_q.size(), 6);
        for (int k = 0; k < 6 && k < log_q.size(); k++)
            chk(nm, log_q[k], lit[k]);
    endtask

    initial begin : main
        int c;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_ack", bus.req_ack, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_sof_last", {bus.out_sof, bus.out_last}, 0);
        chk("rst_pl_ready", bus.pl_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: all four requesters held for two rounds, pointer starts at 0
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                add_hdr(i, 32'h100 + i, r, 32'h200 + i, 13'd1);
                add_pl(i, 32'h5000 + 16 * r + i);
            end
        expg = '{0, 1, 2, 3, 0, 1, 2, 3};
        wait_done("t2_done");

        // T1: single transaction
        log_q.delete();
        add_hdr(0, 32'hA1, 32'd5, 32'hD2, 13'd2);
        add_pl(0, 32'h11);
        add_pl(0, 32'h22);
        expg = '{0};
        wait_done("t1_done");
        chk_t1_log("t1_stream");

        // T3: zero-length transaction on req2
        nopl = 1'b1;
        add_hdr(2, 32'hC3, 32'd9, 32'hE4, 13'd0);
        expg = '{2};
        wait_done("t3_done");
        nopl = 1'b0;

        // T4: T1 again with out_ready toggling
        log_q.delete();
        rmode = 1;
        add_hdr(0, 32'hA1, 32'd5, 32'hD2, 13'd2);
        add_pl(0, 32'h11);
        add_pl(0, 32'h22);
        expg = '{0};
        wait_done("t4_done");
        rmode = 0;
        chk_t1_log("t4_stream");

        // T5: oversize header on req1, req2 served next
        c = err_cnt;
        add_hdr(1, 32'hBAD, 32'd1, 32'hBAD, 13'd4097);
        add_hdr(2, 32'h77, 32'd3, 32'h88, 13'd1);
        add_pl(2, 32'h99);
        expg = '{1, 2};
        wait_done("t5_done");
        chk("t5_err_count", err_cnt - c, 1);

`ifdef SVCS_ARB_TIMEOUT_EN
        // T6: one payload word then a stall
        add_hdr(0, 32'h61, 32'd6, 32'h62, 13'd3);
        plq[0].push_back(32'h33);
        epl[0].push_back(32'h33);
        epl[0].push_back(32'h0);
        epl[0].push_back(32'h0);
        expg = '{0};
        wait_done("t6_done");
        chk("t6_timeout_count", tmo_cnt, 1);
`else
        chk("timeout_tied_low", tmo_cnt, 0);
`endif

        // Reset in the middle of a transaction
        log_q.delete();
        add_hdr(0, 32'hF0, 32'd1, 32'hF1, 13'd3);
        for (int k = 0; k < 3; k++) add_pl(0, 32'hF00 + k);
        expg = '{0};
        c = 0;
        while (log_q.size() < 2 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) fail("mid_reset_wait");
        @(posedge clk);
        #3;
        mute  = 1'b1;
        rst_n = 1'b0;
        expq.delete();
        expg.delete();
        for (int i = 0; i < N; i++) begin
            hq[i].delete();
            plq[i].delete();
            epl[i].delete();
        end
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_last", bus.out_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_grant_id", grant_id, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mute = 1'b0;

        // pointer back at 0 after reset: req0 ahead of req1
        add_hdr(1, 32'h11, 32'd1, 32'h12, 13'd0);
        add_hdr(0, 32'h01, 32'd0, 32'h02, 13'd0);
        expg = '{0, 1};
        wait_done("post_reset_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
